// File: rtl/ofdm_add_cp.sv
// ofdm_add_cp: cyclic-prefix insertion over a two-bank ping-pong buffer.
// The writer fills one bank while the reader replays the other, tail first.
module ofdm_add_cp #(
    parameter int DATA_SIZE    = 16,
    parameter int SYMBOLS_SIZE = 256,
    parameter int CP_LENGHT    = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [DATA_SIZE-1:0] in_data_i,
    input  logic [DATA_SIZE-1:0] in_data_q,
    input  logic                 i_frame_sync,
    output logic                 out_valid,
    input  logic                 i_out_ready,
    output logic [DATA_SIZE-1:0] out_data_i,
    output logic [DATA_SIZE-1:0] out_data_q,
    output logic                 out_symbol_start
);

    localparam int AW = (SYMBOLS_SIZE > 1) ? $clog2(SYMBOLS_SIZE) : 1;
    localparam int SW = 2 * DATA_SIZE;
    localparam logic [AW-1:0] ADDR_LAST = AW'(SYMBOLS_SIZE - 1);
    localparam logic [AW-1:0] ADDR_CP   = AW'(SYMBOLS_SIZE - CP_LENGHT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CP,
        S_BODY
    } rd_state_t;

    logic [SW-1:0] mem [2][SYMBOLS_SIZE];

    logic          ready_en;
    logic          wr_bank;
    logic [AW-1:0] wr_addr;
    logic          wr_accept;
    logic          wr_last;
    logic [1:0]    full;
    logic [1:0]    set_full;
    logic [1:0]    clr_full;

    rd_state_t     state;
    rd_state_t     state_nx;
    logic          rd_bank;
    logic          rd_bank_nx;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] rd_addr_nx;
    logic [SW-1:0] data_q;
    logic [SW-1:0] data_nx;
    logic          sos_q;
    logic          sos_nx;
    logic          load;
    logic          release_bank;
    logic          fire;

    // Writer handshake: stall only when the bank being written is still owned
    assign o_ready   = ready_en && !full[wr_bank];
    assign wr_accept = i_valid && o_ready && !i_frame_sync;
    assign wr_last   = wr_accept && (wr_addr == ADDR_LAST);

    // Ready comes up on the first edge after reset release
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    // Write address and bank sequencing; frame sync restarts the symbol
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_addr <= '0;
            wr_bank <= 1'b0;
        end else if (i_frame_sync) begin
            wr_addr <= '0;
        end else if (wr_accept) begin
            if (wr_last) begin
                wr_addr <= '0;
                wr_bank <= ~wr_bank;
            end else begin
                wr_addr <= wr_addr + 1'b1;
            end
        end
    end

    // Sample storage; contents survive reset and are simply overwritten
    always_ff @(posedge i_clk) begin
        if (wr_accept) begin
            mem[wr_bank][wr_addr] <= {in_data_i, in_data_q};
        end
    end

    // Full-flag set/clear requests from writer and reader
    always_comb begin
        set_full = '0;
        clr_full = '0;
        if (wr_last) begin
            set_full[wr_bank] = 1'b1;
        end
        if (release_bank) begin
            clr_full[rd_bank] = 1'b1;
        end
    end

    // Bank ownership flags; release and fill in one cycle both land
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            full <= '0;
        end else begin
            full <= (full & ~clr_full) | set_full;
        end
    end

    assign fire = (state != S_IDLE) && i_out_ready;

    // Reader next-state: prefix from the tail, then the whole body
    always_comb begin
        state_nx     = state;
        rd_bank_nx   = rd_bank;
        rd_addr_nx   = rd_addr;
        data_nx      = data_q;
        sos_nx       = sos_q;
        load         = 1'b0;
        release_bank = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (full[rd_bank]) begin
                    state_nx   = S_CP;
                    rd_addr_nx = ADDR_CP;
                    sos_nx     = 1'b1;
                    load       = 1'b1;
                end
            end
            S_CP: begin
                if (fire) begin
                    sos_nx = 1'b0;
                    load   = 1'b1;
                    if (rd_addr == ADDR_LAST) begin
                        state_nx   = S_BODY;
                        rd_addr_nx = '0;
                    end else begin
                        rd_addr_nx = rd_addr + 1'b1;
                    end
                end
            end
            S_BODY: begin
                if (fire) begin
                    if (rd_addr == ADDR_LAST) begin
                        release_bank = 1'b1;
                        rd_bank_nx   = ~rd_bank;
                        rd_addr_nx   = ADDR_CP;
                        if (full[~rd_bank]) begin
                            state_nx = S_CP;
                            sos_nx   = 1'b1;
                            load     = 1'b1;
                        end else begin
                            state_nx = S_IDLE;
                            sos_nx   = 1'b0;
                            data_nx  = '0;
                        end
                    end else begin
                        rd_addr_nx = rd_addr + 1'b1;
                        sos_nx     = 1'b0;
                        load       = 1'b1;
                    end
                end
            end
            default: begin
                state_nx = S_IDLE;
                sos_nx   = 1'b0;
                data_nx  = '0;
            end
        endcase
        if (load) begin
            data_nx = mem[rd_bank_nx][rd_addr_nx];
        end
    end

    // Reader state and registered output sample
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state   <= S_IDLE;
            rd_bank <= 1'b0;
            rd_addr <= '0;
            data_q  <= '0;
            sos_q   <= 1'b0;
        end else begin
            state   <= state_nx;
            rd_bank <= rd_bank_nx;
            rd_addr <= rd_addr_nx;
            data_q  <= data_nx;
            sos_q   <= sos_nx;
        end
    end

    assign out_valid        = (state != S_IDLE);
    assign out_data_i       = data_q[SW-1:DATA_SIZE];
    assign out_data_q       = data_q[DATA_SIZE-1:0];
    assign out_symbol_start = sos_q;

endmodule

// File: tb/tb_ofdm_add_cp.sv
// tb_ofdm_add_cp: randomized bench for ofdm_add_cp with a queue-based
// model of symbols, prefixes and bank occupancy.
module tb_ofdm_add_cp;

    localparam int DW = 16;
    localparam int N  = 8;
    localparam int CP = 2;

    logic          clk;
    logic          rst_n;
    logic          i_valid;
    logic          o_ready;
    logic [DW-1:0] in_data_i;
    logic [DW-1:0] in_data_q;
    logic          i_frame_sync;
    logic          out_valid;
    logic          i_out_ready;
    logic [DW-1:0] out_data_i;
    logic [DW-1:0] out_data_q;
    logic          out_symbol_start;

    ofdm_add_cp #(
        .DATA_SIZE   (DW),
        .SYMBOLS_SIZE(N),
        .CP_LENGHT   (CP)
    ) dut (
        .i_clk           (clk),
        .i_reset_n       (rst_n),
        .i_valid         (i_valid),
        .o_ready         (o_ready),
        .in_data_i       (in_data_i),
        .in_data_q       (in_data_q),
        .i_frame_sync    (i_frame_sync),
        .out_valid       (out_valid),
        .i_out_ready     (i_out_ready),
        .out_data_i      (out_data_i),
        .out_data_q      (out_data_q),
        .out_symbol_start(out_symbol_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] src[$];
    logic [31:0] cur[$];
    logic [31:0] exp_d[$];
    bit          exp_s[$];
    int          bfull = 0;
    int          out_idx = 0;
    int          n_out = 0;
    int          ncyc = 0;
    int          rise_cyc = -1;
    int          last_full_cyc = -1;
    bit          rdy_en = 0;
    bit          prev_stall = 0;
    bit          prev_valid = 0;
    bit          prev_sos = 0;
    logic [31:0] prev_obs = '0;
    int          omode = 0;
    int          vpct = 100;
    bit          junk_fs = 0;
    bit          rnd_fs = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic model_clear();
        cur.delete();
        exp_d.delete();
        exp_s.delete();
        bfull      = 0;
        out_idx    = 0;
        rdy_en     = 0;
        prev_stall = 0;
        prev_valid = 0;
        prev_sos   = 0;
    endtask

    // One clock: check outputs, drive inputs, advance the model
    task automatic cycle();
        logic [31:0] obs;
        logic        acc;
        logic        ofire;
        @(negedge clk);
        ncyc++;
        obs = {out_data_i, out_data_q};
        chk("o_ready", o_ready, rdy_en && (bfull < 2));
        if (out_valid && !prev_valid) rise_cyc = ncyc;
        if (!out_valid) begin
            chk("idle_data", obs, 0);
            chk("idle_sos", out_symbol_start, 0);
        end
        if (prev_stall) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", obs, prev_obs);
            chk("hold_sos", out_symbol_start, prev_sos);
        end
        i_frame_sync = junk_fs || (rnd_fs && $urandom_range(39) == 0);
        if (junk_fs) begin
            i_valid   = 1'b1;
            in_data_i = 16'h0bad;
            in_data_q = 16'h0bad;
        end else begin
            i_valid = (src.size() > 0) && ($urandom_range(99) < vpct);
            if (src.size() > 0) {in_data_i, in_data_q} = src[0];
            else {in_data_i, in_data_q} = $urandom;
        end
        junk_fs = 0;
        case (omode)
            0:       i_out_ready = 1'b1;
            1:       i_out_ready = 1'($urandom_range(1));
            default: i_out_ready = 1'b0;
        endcase
        acc   = i_valid && o_ready && !i_frame_sync;
        ofire = out_valid && i_out_ready;
        if (ofire) begin
            n_out++;
            chk("out_expected", exp_d.size() > 0, 1);
            if (exp_d.size() > 0) begin
                chk("out_data", obs, exp_d.pop_front());
                chk("out_sos", out_symbol_start, exp_s.pop_front());
            end
            out_idx++;
            if (out_idx == N + CP) begin
                out_idx = 0;
                bfull--;
            end
        end
        if (i_frame_sync) begin
            cur.delete();
        end else if (acc) begin
            cur.push_back(src.pop_front());
            if (cur.size() == N) begin
                for (int k = N - CP; k < N; k++) begin
                    exp_d.push_back(cur[k]);
                    exp_s.push_back(k == N - CP);
                end
                for (int k = 0; k < N; k++) begin
                    exp_d.push_back(cur[k]);
                    exp_s.push_back(1'b0);
                end
                bfull++;
                last_full_cyc = ncyc;
                cur.delete();
            end
        end
        prev_stall = out_valid && !i_out_ready;
        prev_obs   = obs;
        prev_sos   = out_symbol_start;
        prev_valid = out_valid;
        rdy_en     = 1;
    endtask

    task automatic push_seq(input int first, input int cnt);
        for (int k = 0; k < cnt; k++) begin
            src.push_back({16'(first + k), 16'($urandom)});
        end
    endtask

    task automatic wait_src(input int bound);
        for (int k = 0; k < bound; k++) begin
            if (src.size() == 0) break;
            cycle();
        end
        chk("src_taken", src.size(), 0);
    endtask

    task automatic drain(input int mode, input int bound);
        omode  = mode;
        vpct   = 100;
        rnd_fs = 0;
        for (int k = 0; k < bound; k++) begin
            if (src.size() == 0 && exp_d.size() == 0) break;
            cycle();
        end
        chk("drain_src", src.size(), 0);
        chk("drain_exp", exp_d.size(), 0);
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #2;
        chk("pre_rst_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", o_ready, 0);
        chk("rst_data", {out_data_i, out_data_q}, 0);
        chk("rst_sos", out_symbol_start, 0);
        model_clear();
        @(negedge clk);
        i_valid      = 1'b0;
        i_frame_sync = 1'b0;
        rst_n        = 1'b1;
        rdy_en       = 1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int ocnt;
        int gaps;
        rst_n        = 1'b1;
        i_valid      = 1'b0;
        in_data_i    = '0;
        in_data_q    = '0;
        i_frame_sync = 1'b0;
        i_out_ready  = 1'b0;
        #1 rst_n = 1'b0;
        #10;
        chk("init_ready", o_ready, 0);
        chk("init_valid", out_valid, 0);
        chk("init_data", {out_data_i, out_data_q}, 0);
        chk("init_sos", out_symbol_start, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        rdy_en = 1;

        // single symbol at full rate, latency check
        omode    = 0;
        vpct     = 100;
        rise_cyc = -1;
        base     = n_out;
        push_seq(1, N);
        wait_src(40);
        for (int k = 0; k < 20 && rise_cyc < 0; k++) cycle();
        chk("latency", rise_cyc - last_full_cyc, 2);
        drain(0, 60);
        chk("single_cnt", n_out - base, N + CP);

        // continuous input and sink
        push_seq(100, 64);
        ocnt = 0;
        gaps = 0;
        for (int k = 0; k < 60; k++) begin
            cycle();
            if (k >= 30 && k < 50 && o_ready) ocnt++;
            if (k >= 20 && !out_valid) gaps++;
        end
        chk("ready_duty", ocnt, 16);
        chk("no_gap", gaps, 0);
        drain(0, 200);

        // random sink back-pressure
        base = n_out;
        push_seq(1, N);
        drain(1, 200);
        chk("rnd_sink_cnt", n_out - base, N + CP);

        // frame sync after sample 5
        base = n_out;
        omode = 0;
        push_seq(1, 5);
        wait_src(20);
        junk_fs = 1;
        cycle();
        push_seq(11, N);
        drain(0, 80);
        chk("fsync_cnt", n_out - base, N + CP);

        // reset mid-body
        base = n_out;
        push_seq(1, N);
        for (int k = 0; k < 60 && n_out - base < CP + 3; k++) cycle();
        chk("mid_body", n_out - base, CP + 3);
        reset_pulse();
        base = n_out;
        push_seq(21, N);
        drain(0, 80);
        chk("post_rst_cnt", n_out - base, N + CP);

        // long downstream stall with continuous input
        base  = n_out;
        omode = 2;
        push_seq(200, 40);
        for (int k = 0; k < 30; k++) cycle();
        chk("stall_ready", o_ready, 0);
        chk("stall_valid", out_valid, 1);
        drain(0, 200);
        chk("stall_cnt", n_out - base, 5 * (N + CP));

        // random traffic with occasional frame sync
        omode  = 1;
        vpct   = 70;
        rnd_fs = 1;
        for (int k = 0; k < 600; k++) begin
            if (src.size() < 4) src.push_back($urandom);
            cycle();
        end
        drain(1, 400);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
